// File: rtl/inv_sub_bytes_seq_pkg.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq_pkg
// Shared AES decryption definitions used by the sequential InvSubBytes block:
//   - FSM state encoding (IDLE/RUN/DONE)
//   - byte count of one AES state and its width in bits
//   - the set of legal LANES values and a helper to test membership
// -----------------------------------------------------------------------------
package inv_sub_bytes_seq_pkg;

  localparam int NUM_BYTES = 16;
  localparam int STATE_W   = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NUM_LEGAL_LANES = 5;
  localparam int LEGAL_LANES [NUM_LEGAL_LANES] = '{1, 2, 4, 8, 16};

  // Elaboration-time check that a LANES value divides the state evenly
  // into power-of-two chunks.
  function automatic bit lanes_legal(input int lanes);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_LANES; i++) begin
      if (LEGAL_LANES[i] == lanes) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_if.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq_if
// Handshake bundle of the sequential InvSubBytes block.
//   in_valid/in_ready/D_in     : input state handshake (128-bit AES state)
//   out_valid/out_ready/D_out  : result handshake
//   busy                       : block is not in IDLE
// Modports:
//   slave  - the InvSubBytes block itself
//   master - the producer/consumer driving it
// -----------------------------------------------------------------------------
interface inv_sub_bytes_seq_if;
  import inv_sub_bytes_seq_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [STATE_W-1:0] D_in;
  logic               out_valid;
  logic               out_ready;
  logic [STATE_W-1:0] D_out;
  logic               busy;

  modport slave (
    input  in_valid, D_in, out_ready,
    output in_ready, out_valid, D_out, busy
  );

  modport master (
    output in_valid, D_in, out_ready,
    input  in_ready, out_valid, D_out, busy
  );

endinterface

// File: rtl/inv_sub_bytes_seq_sbox.sv
// -----------------------------------------------------------------------------
// inv_S_box
// Combinational AES inverse substitution box (FIPS-197 InvSbox).
//   i_in  : 8-bit input byte
//   o_out : 8-bit inverse-substituted byte
// -----------------------------------------------------------------------------
module inv_S_box (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  // Row r, column c holds InvSbox[16*r + c].
  localparam logic [7:0] INV_TBL [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign o_out = INV_TBL[i_in];

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes_seq
// Sequential AES InvSubBytes: applies the inverse S-box to all 16 bytes of a
// 128-bit state using LANES shared inv_S_box instances, LANES bytes per cycle.
//
// Parameters:
//   LANES  : inv_S_box instances / bytes processed per RUN cycle (1,2,4,8,16)
// Ports:
//   clk    : single rising-edge clock
//   rst    : synchronous active-high reset
//   bus    : inv_sub_bytes_seq_if.slave
//            in_valid/in_ready/D_in, out_valid/out_ready/D_out, busy
//
// Optional feature (macro INV_SUB_BYTES_SEQ_PIPE_EN):
//   When defined, S-box outputs and their chunk index are registered before
//   write-back, so RUN lasts 16/LANES+1 cycles. Without it, write-back is
//   combinational and RUN lasts 16/LANES cycles.
// -----------------------------------------------------------------------------
module inv_sub_bytes_seq
  import inv_sub_bytes_seq_pkg::*;
#(
  parameter int LANES = 4
) (
  input logic               clk,
  input logic               rst,
  inv_sub_bytes_seq_if.slave bus
);

  localparam int NCHUNK = NUM_BYTES / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("inv_sub_bytes_seq: LANES=%0d is not one of 1,2,4,8,16", LANES);
  end

  state_t             r_fsm;
  logic [CNT_W-1:0]   r_cnt;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [7:0]         w_sbox_in  [LANES];
  logic [7:0]         w_sbox_out [LANES];

  // Write-back port: which chunk is being written and with what bytes.
  logic               w_wb_en;
  logic [CNT_W-1:0]   w_wb_idx;
  logic [7:0]         w_wb_data [LANES];
  logic               w_wb_last;

  // First byte index of chunk c. With a single chunk the counter bit is
  // meaningless, so the base is pinned to 0 to keep the select in range.
  function automatic int chunk_base(input logic [CNT_W-1:0] c);
    return (NCHUNK > 1) ? int'(c) * LANES : 0;
  endfunction

  // Stage p0: select the current chunk and substitute it
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_sbox_in[l] = r_state[8*(chunk_base(r_cnt)+l) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_S_box u_inv_sbox (
      .i_in  (w_sbox_in[g]),
      .o_out (w_sbox_out[g])
    );
  end

`ifdef INV_SUB_BYTES_SEQ_PIPE_EN
  logic               r_vld_p1;
  logic [CNT_W-1:0]   r_idx_p1;
  logic [7:0]         r_sbox_p1 [LANES];
  // Set once the last chunk has entered the pipe register; stops issuing
  // while that final chunk drains into the state register.
  logic               r_issue_done;

  // Stage p1: registered S-box results awaiting write-back
  always_ff @(posedge clk) begin
    if (r_fsm == RUN && !r_issue_done) begin
      for (int l = 0; l < LANES; l++) r_sbox_p1[l] <= w_sbox_out[l];
      r_idx_p1 <= r_cnt;
    end
  end

  assign w_wb_en  = r_vld_p1;
  assign w_wb_idx = r_idx_p1;
  always_comb begin
    for (int l = 0; l < LANES; l++) w_wb_data[l] = r_sbox_p1[l];
  end
`else
  assign w_wb_en  = (r_fsm == RUN);
  assign w_wb_idx = r_cnt;
  always_comb begin
    for (int l = 0; l < LANES; l++) w_wb_data[l] = w_sbox_out[l];
  end
`endif

  assign w_wb_last = w_wb_en && (w_wb_idx == LAST_CHUNK);

  // Merge the substituted chunk into the state; other bytes pass through.
  always_comb begin
    w_state_nxt = r_state;
    for (int l = 0; l < LANES; l++) begin
      w_state_nxt[8*(chunk_base(w_wb_idx)+l) +: 8] = w_wb_data[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm       <= IDLE;
      r_cnt       <= '0;
      r_state     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef INV_SUB_BYTES_SEQ_PIPE_EN
      r_vld_p1     <= 1'b0;
      r_issue_done <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        IDLE: begin
          if (bus.in_valid && r_in_ready) begin
            r_state    <= bus.D_in;
            r_cnt      <= '0;
            r_fsm      <= RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
`ifdef INV_SUB_BYTES_SEQ_PIPE_EN
            r_vld_p1     <= 1'b0;
            r_issue_done <= 1'b0;
`endif
          end
        end

        RUN: begin
          if (w_wb_en) r_state <= w_state_nxt;
`ifdef INV_SUB_BYTES_SEQ_PIPE_EN
          r_vld_p1 <= !r_issue_done;
          if (!r_issue_done) begin
            if (r_cnt == LAST_CHUNK) begin
              r_cnt        <= '0;
              r_issue_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
`else
          if (r_cnt == LAST_CHUNK) r_cnt <= '0;
          else                     r_cnt <= r_cnt + 1'b1;
`endif
          if (w_wb_last) begin
            r_fsm       <= DONE;
            r_out_valid <= 1'b1;
          end
        end

        DONE: begin
          // The exit cycle never accepts: in_ready only rises once in IDLE.
          if (bus.out_ready) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end

        default: begin
          r_fsm       <= IDLE;
          r_cnt       <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.D_out     = r_state;

endmodule

// File: doc/inv_sub_bytes_seq.md
INV_SUB_BYTES_SEQ -- requirements
Module: inv_sub_bytes_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, number of inv_S_box instances shared across the 16 state bytes; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have: in_valid  input  1  D_in holds a state to transform.
REQ-005 SHALL have: in_ready  output  1  block can accept D_in.
REQ-006 SHALL have: D_in  input  128  input state; byte i = bits 8i+7:8i.
REQ-007 SHALL have: out_valid  output  1  D_out holds the finished result.
REQ-008 SHALL have: out_ready  input  1  consumer accepts D_out.
REQ-009 SHALL have: D_out  output  128  inverse-substituted state.
REQ-010 SHALL have: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: in_ready=1; on in_valid&in_ready, SHALL load D_in into a 128-bit state register, clear the chunk counter and go to RUN.
REQ-013 RUN: each cycle SHALL replace bytes c*LANES .. c*LANES+LANES-1 of the state register with their inverse S-box values (c = chunk counter), then increment c.
REQ-014 Chunk counter width SHALL be clog2(16/LANES), minimum 1 bit; after the last chunk (c = 16/LANES-1) the FSM SHALL go to DONE and the counter SHALL wrap to 0.
REQ-015 DONE: out_valid=1, D_out = state register; on out_ready SHALL go to IDLE; without out_ready SHALL hold DONE with D_out stable.
REQ-016 Latency, macro absent: handshake accepted at edge k gives out_valid high from edge k+16/LANES (LANES=4: 4 cycles; LANES=16: 1 cycle).
REQ-017 in_ready SHALL be 0 in RUN and DONE; in_valid there SHALL be ignored; no input is accepted in the cycle DONE is left.
REQ-018 Bytes not in the current chunk SHALL be held unchanged; each byte SHALL be substituted exactly once per transaction.
REQ-019 D_out SHALL always drive the state register; its value is defined only while out_valid=1.

Reset
REQ-020 rst SHALL force IDLE, counter 0, state register 0, in_ready=1, out_valid=0, busy=0, D_out=0 at the next edge.
REQ-021 rst asserted in RUN or DONE SHALL abort the transaction with no out_valid pulse; rst SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-022 Macro INV_SUB_BYTES_SEQ_PIPE_EN SHALL, when defined, register the LANES S-box outputs and their chunk index before write-back, making RUN last 16/LANES+1 cycles and adding 1 cycle to latency.
REQ-023 Without INV_SUB_BYTES_SEQ_PIPE_EN, S-box outputs SHALL write back combinationally in the same cycle, per REQ-016.
REQ-024 Handshake rules, reset values and results SHALL be identical with and without the macro.

Structure
REQ-025 Shared AES decryption package SHALL hold FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the byte count 16 and the legal LANES set.
REQ-026 SHALL instantiate the existing inv_S_box module LANES times as its only sub-module; no other S-box copy.
REQ-027 Illegal LANES SHALL be rejected at elaboration.

Verification
REQ-028 D_in = 128'h6363..63, out_ready=1 -> D_out = 128'h0, out_valid after 4 cycles (LANES=4, macro off), 5 with macro on.
REQ-029 D_in = 128'h0 -> D_out = 128'h5252..52; D_in bytes 0x7C/0xFF alternating -> bytes 0x01/0x7D.
REQ-030 out_ready held 0 for 10 cycles in DONE -> out_valid and D_out stable, in_ready=0, in_valid pulses ignored.
REQ-031 rst pulsed on second RUN cycle -> next cycle IDLE, out_valid=0, D_out=0; following transaction correct.
REQ-032 Sweep LANES 1, 2, 4, 8, 16 with 100 random states -> match bytewise inverse S-box reference, latency 16/LANES cycles (plus 1 with macro).
REQ-033 Back-to-back in_valid with out_ready=1 -> one transaction per 16/LANES+2 cycles, none lost or duplicated.
